// File: rtl/writeback_arbiter_pkg.sv
// Shared types and default sizing for the register-file writeback arbiter.
// The result record travels from the execution units to the writeback ports.
package writeback_arbiter_pkg;

  localparam int WB_NUM_REQ   = 4;
  localparam int WB_NUM_PORTS = 2;

  localparam int XLEN        = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int NUM_WB_REGS = 2;   // destinations a single result may write
  localparam int TRANS_ID_W  = 3;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t [NUM_WB_REGS-1:0] writereg;
    logic [XLEN-1:0]             result;
    logic [TRANS_ID_W-1:0]       trans_id;
  } writeback_data_t;

  typedef struct packed {
    logic            valid;
    writeback_data_t data;
  } wb_port_t;

endpackage

// File: rtl/wb_rr_select.sv
// Combinational round-robin scan: grants up to NUM_PORTS requesters starting at
// rr_ptr, skipping any whose nonzero destinations collide with an earlier grant.
module wb_rr_select
  import writeback_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = WB_NUM_REQ,
  parameter int NUM_PORTS = WB_NUM_PORTS,
  parameter int PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int PSEL_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_REQ-1:0]                        valid,
  input  reg_addr_t [NUM_REQ-1:0][NUM_WB_REGS-1:0]  dest,
  input  logic [PTR_W-1:0]                          rr_ptr,
  output logic [NUM_REQ-1:0]                        grant,
  output logic [NUM_PORTS-1:0]                      port_valid,
  output logic [NUM_PORTS-1:0][PTR_W-1:0]           port_sel,
  output logic                                      any_grant,
  output logic [PTR_W-1:0]                          last_idx,
  output logic                                      conflict
);

  localparam int NUM_ARCH_REGS = 2 ** REG_ADDR_W;
  localparam int CNT_W         = $clog2(NUM_PORTS + 1);

  localparam logic [PTR_W:0]   NUM_REQ_L   = (PTR_W + 1)'(NUM_REQ);
  localparam logic [CNT_W-1:0] NUM_PORTS_L = CNT_W'(NUM_PORTS);

  logic [NUM_ARCH_REGS-1:0] claimed;
  logic [CNT_W-1:0]         n_grant;
  logic [PTR_W:0]           idx_ext;
  logic [PTR_W-1:0]         idx;
  logic                     hit;

  // NOTE: every variable gets a default before the loop; a path that skipped
  // an assignment would otherwise infer a latch.
  always_comb begin
    grant      = '0;
    port_valid = '0;
    port_sel   = '0;
    any_grant  = 1'b0;
    last_idx   = rr_ptr;
    conflict   = 1'b0;
    claimed    = '0;
    n_grant    = '0;
    idx_ext    = '0;
    idx        = '0;
    hit        = 1'b0;

    for (int i = 0; i < NUM_REQ; i++) begin
      idx_ext = {1'b0, rr_ptr} + (PTR_W + 1)'(i);
      if (idx_ext >= NUM_REQ_L) idx_ext = idx_ext - NUM_REQ_L;
      idx = idx_ext[PTR_W-1:0];

      // x0 is a discard target, so it never blocks anyone
      hit = 1'b0;
      for (int j = 0; j < NUM_WB_REGS; j++) begin
        if (dest[idx][j] != '0 && claimed[dest[idx][j]]) hit = 1'b1;
      end

      if (valid[idx]) begin
        if (n_grant == NUM_PORTS_L) begin
          // out of ports: deferred, but not counted as a conflict
        end else if (hit) begin
          conflict = 1'b1;
        end else begin
          grant[idx]                       = 1'b1;
          port_valid[n_grant[PSEL_W-1:0]]  = 1'b1;
          port_sel[n_grant[PSEL_W-1:0]]    = idx;
          n_grant                          = n_grant + CNT_W'(1);
          last_idx                         = idx;
          any_grant                        = 1'b1;
          for (int j = 0; j < NUM_WB_REGS; j++) begin
            claimed[dest[idx][j]] = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: round-robin grants execution-unit results onto the
// register-file write ports through a single registered output stage.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = WB_NUM_REQ,
  parameter int NUM_PORTS = WB_NUM_PORTS
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                flush,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  writeback_data_t [NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic [NUM_PORTS-1:0]                wb_valid,
  output writeback_data_t [NUM_PORTS-1:0]     wb_data,
  output logic [31:0]                         conflict_cnt
);

  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PSEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [PTR_W:0] NUM_REQ_L = (PTR_W + 1)'(NUM_REQ);

  logic [PTR_W-1:0]                          rr_ptr;
  logic [PTR_W-1:0]                          ptr_next;
  logic [PTR_W:0]                            ptr_inc;
  logic [NUM_REQ-1:0]                        scan_valid;
  reg_addr_t [NUM_REQ-1:0][NUM_WB_REGS-1:0]  req_dest;
  logic [NUM_REQ-1:0]                        grant;
  logic [NUM_PORTS-1:0]                      port_valid;
  logic [NUM_PORTS-1:0][PTR_W-1:0]           port_sel;
  logic                                      any_grant;
  logic [PTR_W-1:0]                          last_idx;
  logic                                      conflict;
  wb_port_t [NUM_PORTS-1:0]                  stage_d;
  wb_port_t [NUM_PORTS-1:0]                  stage_q;

  // Masking the scan input suppresses grants and conflict counting together.
  assign scan_valid = req_valid & {NUM_REQ{~(flush | reset)}};

  always_comb begin
    req_dest = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      req_dest[r] = req_data[r].writereg;
    end
  end

  wb_rr_select #(
    .NUM_REQ   (NUM_REQ),
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W),
    .PSEL_W    (PSEL_W)
  ) u_select (
    .valid      (scan_valid),
    .dest       (req_dest),
    .rr_ptr     (rr_ptr),
    .grant      (grant),
    .port_valid (port_valid),
    .port_sel   (port_sel),
    .any_grant  (any_grant),
    .last_idx   (last_idx),
    .conflict   (conflict)
  );

  assign req_ready = grant;

  assign ptr_inc  = {1'b0, last_idx} + (PTR_W + 1)'(1);
  assign ptr_next = (ptr_inc == NUM_REQ_L) ? '0 : ptr_inc[PTR_W-1:0];

  // Unused ports keep their old payload; only the valid bit is refreshed.
  always_comb begin
    stage_d = stage_q;
    for (int k = 0; k < NUM_PORTS; k++) begin
      stage_d[k].valid = port_valid[k];
      if (port_valid[k]) stage_d[k].data = req_data[port_sel[k]];
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: the payload is reset as well because wb_data must read zero out of
  // reset; a deep result buffer would normally leave its data unreset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q      <= '0;
      rr_ptr       <= '0;
      conflict_cnt <= '0;
    end else begin
      stage_q <= stage_d;
      if (any_grant) rr_ptr <= ptr_next;
      if (conflict && conflict_cnt != '1) conflict_cnt <= conflict_cnt + 32'd1;
    end
  end

  always_comb begin
    wb_valid = '0;
    wb_data  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      wb_valid[k] = stage_q[k].valid;
      wb_data[k]  = stage_q[k].data;
    end
  end

  a_ready_needs_valid: assert property (@(posedge clk) disable iff (reset)
    (req_ready & ~req_valid) == '0);
  a_ports_not_oversubscribed: assert property (@(posedge clk) disable iff (reset)
    $countones(req_ready) <= NUM_PORTS);

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed vector table, reset sequences and
// randomized traffic compared against a queue-style arbitration model.
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        flush;
  logic [3:0]                  req_valid;
  writeback_data_t [3:0]       req_data;
  logic [3:0]                  req_ready;
  logic [1:0]                  wb_valid;
  writeback_data_t [1:0]       wb_data;
  logic [31:0]                 conflict_cnt;

  always #5 clk = ~clk;

  writeback_arbiter #(.NUM_REQ(4), .NUM_PORTS(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .wb_valid     (wb_valid),
    .wb_data      (wb_data),
    .conflict_cnt (conflict_cnt)
  );

  int checks   = 0;
  int failures = 0;

  // reference state
  int                 m_ptr = 0;
  logic [1:0]         m_wbv = '0;
  writeback_data_t    m_wbd [2];
  logic [31:0]        m_cnt = '0;
  logic [3:0]         obs_ready;

  typedef struct packed {
    logic [3:0]      valid;
    logic [3:0][4:0] d;
    logic            fl;
    logic [3:0]      ready;
    logic [1:0]      wbv;
    logic [4:0]      wr0;
    logic [4:0]      wr1;
    logic [7:0]      cnt;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk_vec(input logic [3:0] v, input int a, input int b, input int c,
                                  input int e, input logic fl, input logic [3:0] rdy,
                                  input logic [1:0] wbv, input int w0, input int w1, input int cnt);
    vec_t t;
    t.valid = v;
    t.d[0] = 5'(a); t.d[1] = 5'(b); t.d[2] = 5'(c); t.d[3] = 5'(e);
    t.fl = fl; t.ready = rdy; t.wbv = wbv;
    t.wr0 = 5'(w0); t.wr1 = 5'(w1); t.cnt = 8'(cnt);
    return t;
  endfunction

  function automatic writeback_data_t mk_data(input int r, input int d0, input int d1);
    writeback_data_t x;
    x.writereg[0] = 5'(d0);
    x.writereg[1] = 5'(d1);
    x.result      = $urandom;
    x.trans_id    = 3'(r);
    return x;
  endfunction

  // Walk the requesters in rotation order, keeping a set of claimed registers.
  function automatic void model_arb(input int ptr, input logic [3:0] v,
                                    input writeback_data_t [3:0] d,
                                    output logic [3:0] g, output int sel [2],
                                    output int ngr, output bit confl);
    bit taken [int];
    g = '0; ngr = 0; confl = 0; sel[0] = 0; sel[1] = 0;
    for (int step = 0; step < 4; step++) begin
      int r;
      bit clash;
      r = (ptr + step) % 4;
      if (!v[r]) continue;
      clash = 0;
      for (int e = 0; e < NUM_WB_REGS; e++)
        if (d[r].writereg[e] != 0 && taken.exists(int'(d[r].writereg[e]))) clash = 1;
      if (ngr == 2) continue;
      if (clash) begin confl = 1; continue; end
      g[r] = 1'b1;
      sel[ngr] = r;
      ngr++;
      for (int e = 0; e < NUM_WB_REGS; e++) taken[int'(d[r].writereg[e])] = 1;
    end
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_wbv = '0; m_cnt = '0;
    m_wbd[0] = '0; m_wbd[1] = '0;
  endtask

  task automatic do_cycle(input logic [3:0] v, input writeback_data_t [3:0] d, input logic f);
    logic [3:0] g;
    int         sel [2];
    int         ngr;
    bit         confl;
    req_valid = v; req_data = d; flush = f;
    #1;
    model_arb(m_ptr, f ? 4'b0000 : v, d, g, sel, ngr, confl);
    obs_ready = req_ready;
    check("req_ready", 64'(req_ready), 64'(g));
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_wbv[k] = (k < ngr);
      if (k < ngr) m_wbd[k] = d[sel[k]];
    end
    if (ngr > 0) m_ptr = (sel[ngr-1] + 1) % 4;
    if (confl && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    check("wb_valid", 64'(wb_valid), 64'(m_wbv));
    for (int k = 0; k < 2; k++)
      if (m_wbv[k]) check($sformatf("wb_data[%0d]", k), 64'(wb_data[k]), 64'(m_wbd[k]));
    check("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
  endtask

  initial begin
    writeback_data_t [3:0] dd;

    vecs[0]  = mk_vec(4'b1111, 1, 2, 3, 4, 0, 4'b0011, 2'b11, 1, 2, 0);
    vecs[1]  = mk_vec(4'b1111, 5, 6, 7, 8, 0, 4'b1100, 2'b11, 7, 8, 0);
    vecs[2]  = mk_vec(4'b1111, 5, 6, 7, 8, 0, 4'b0011, 2'b11, 5, 6, 0);
    vecs[3]  = mk_vec(4'b1111, 5, 6, 7, 8, 0, 4'b1100, 2'b11, 7, 8, 0);
    vecs[4]  = mk_vec(4'b0111, 9, 9, 3, 0, 0, 4'b0101, 2'b11, 9, 3, 1);
    vecs[5]  = mk_vec(4'b0010, 0, 9, 0, 0, 0, 4'b0010, 2'b01, 9, 0, 1);
    vecs[6]  = mk_vec(4'b0011, 0, 0, 0, 0, 0, 4'b0011, 2'b11, 0, 0, 1);
    vecs[7]  = mk_vec(4'b0111, 1, 1, 3, 0, 1, 4'b0000, 2'b00, 0, 0, 1);
    vecs[8]  = mk_vec(4'b1111, 11, 12, 13, 14, 0, 4'b1100, 2'b11, 13, 14, 1);
    vecs[9]  = mk_vec(4'b0001, 4, 0, 0, 0, 0, 4'b0001, 2'b01, 4, 0, 1);
    vecs[10] = mk_vec(4'b1000, 0, 0, 0, 10, 0, 4'b1000, 2'b01, 10, 0, 1);
    vecs[11] = mk_vec(4'b0000, 1, 2, 3, 4, 0, 4'b0000, 2'b00, 0, 0, 1);
    vecs[12] = mk_vec(4'b1111, 1, 2, 1, 5, 0, 4'b0011, 2'b11, 1, 2, 1);
    vecs[13] = mk_vec(4'b1111, 1, 2, 1, 5, 0, 4'b1100, 2'b11, 1, 5, 1);
    vecs[14] = mk_vec(4'b1111, 7, 7, 7, 8, 0, 4'b1001, 2'b11, 7, 8, 2);

    // Reset held with all units requesting
    reset = 1'b1; flush = 1'b0; req_valid = 4'b1111;
    for (int r = 0; r < 4; r++) dd[r] = mk_data(r, r + 1, 0);
    req_data = dd;
    model_reset();
    #3;
    check("reset wb_valid", 64'(wb_valid), 64'(0));
    check("reset req_ready", 64'(req_ready), 64'(0));
    check("reset conflict_cnt", 64'(conflict_cnt), 64'(0));
    check("reset wb_data", 64'({wb_data[1], wb_data[0]}), 64'(0));
    @(posedge clk); @(posedge clk); #1;
    check("reset held wb_valid", 64'(wb_valid), 64'(0));
    check("reset held req_ready", 64'(req_ready), 64'(0));
    reset = 1'b0;

    // Directed vectors
    for (int i = 0; i < NV; i++) begin
      for (int r = 0; r < 4; r++) dd[r] = mk_data(r, int'(vecs[i].d[r]), 0);
      do_cycle(vecs[i].valid, dd, vecs[i].fl);
      check($sformatf("vec%0d ready", i), 64'(obs_ready), 64'(vecs[i].ready));
      check($sformatf("vec%0d wb_valid", i), 64'(wb_valid), 64'(vecs[i].wbv));
      if (vecs[i].wbv[0])
        check($sformatf("vec%0d port0 writereg", i), 64'(wb_data[0].writereg[0]), 64'(vecs[i].wr0));
      if (vecs[i].wbv[1])
        check($sformatf("vec%0d port1 writereg", i), 64'(wb_data[1].writereg[0]), 64'(vecs[i].wr1));
      check($sformatf("vec%0d conflict_cnt", i), 64'(conflict_cnt), 64'(vecs[i].cnt));
    end

    // Reset mid-operation clears the stage and counter without a clock edge
    req_valid = 4'b1111;
    reset = 1'b1;
    #1;
    check("midreset wb_valid", 64'(wb_valid), 64'(0));
    check("midreset conflict_cnt", 64'(conflict_cnt), 64'(0));
    check("midreset req_ready", 64'(req_ready), 64'(0));
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int r = 0; r < 4; r++) dd[r] = mk_data(r, r + 1, 0);
    do_cycle(4'b1111, dd, 1'b0);
    check("post-reset ready", 64'(obs_ready), 64'(4'b0011));
    check("post-reset port0", 64'(wb_data[0].writereg[0]), 64'(1));
    check("post-reset port1", 64'(wb_data[1].writereg[0]), 64'(2));

    // Randomized traffic with a small destination pool to force conflicts
    for (int n = 0; n < 400; n++) begin
      for (int r = 0; r < 4; r++)
        dd[r] = mk_data(r, $urandom_range(0, 5), ($urandom_range(0, 1) == 1) ? $urandom_range(0, 5) : 0);
      do_cycle(4'($urandom), dd, $urandom_range(0, 15) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
